// File: rtl/bmp_load_ctrl.sv
// rtl/bmp_load_ctrl.sv - streams a BMP file byte-wise into RAM and captures its header fields
// Optional header validation (magic bytes, file size range) is compiled in with BMP_HEADER_CHECK_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif
`ifndef BMP_TOTAL_SIZE
`define BMP_TOTAL_SIZE 256
`endif

module bmp_load_ctrl #(
   parameter int ADDR_W   = `ADDR_WIDTH,
   parameter int DATA_W   = `BYTE_WIDTH,
   parameter int MAX_SIZE = `BMP_TOTAL_SIZE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              RAM_valid,
   output logic [ADDR_W-1:0] RAM_addr,
   output logic [DATA_W-1:0] RAM_D,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [31:0]       file_size,
   output logic [31:0]       data_offset,
   output logic [31:0]       img_width,
   output logic [31:0]       img_height
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HEADER = 3'd1,
      S_PIXEL  = 3'd2,
      S_DONE   = 3'd3,
      S_ERROR  = 3'd4
   } state_t;

   localparam logic [31:0] MAX_U     = 32'(MAX_SIZE);
   localparam logic [31:0] HDR_LAST  = 32'd53;
   localparam logic [31:0] HDR_BYTES = 32'd54;

   state_t            state_q;
   logic [31:0]       cnt_q;
   logic              in_ready_q, busy_q, done_q, error_q;
   logic              ram_valid_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [DATA_W-1:0] ram_d_q;
   logic [31:0]       file_size_q, data_offset_q, img_width_q, img_height_q;

   logic        accept;
   logic [31:0] file_size_d;
   logic [31:0] limit;
   logic        last_byte;
   logic        hdr_bad;
   logic [1:0]  lane;

   assign accept = in_valid && in_ready_q;

   // Every header field starts 2 bytes past a multiple of 4, so the byte lane is (index - 2) mod 4.
   assign lane = cnt_q[1:0] - 2'd2;

   assign file_size_d = (cnt_q == 32'd5) ? {in_data[7:0], file_size_q[23:0]} : file_size_q;

   always_comb begin
      limit = MAX_U;
      if (cnt_q > 32'd5 && file_size_q < MAX_U) begin
         limit = file_size_q;
      end
   end

   // Compared as >= so a declared size already passed (tiny file_size) still terminates the load.
   assign last_byte = (cnt_q + 32'd1) >= limit;

`ifdef BMP_HEADER_CHECK_EN
   assign hdr_bad = accept &&
                    ((cnt_q == 32'd0 && in_data[7:0] != 8'h42) ||
                     (cnt_q == 32'd1 && in_data[7:0] != 8'h4D) ||
                     (cnt_q == 32'd5 && (file_size_d > MAX_U || file_size_d < HDR_BYTES)));
`else
   assign hdr_bad = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         in_ready_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         ram_valid_q   <= 1'b0;
         ram_addr_q    <= '0;
         ram_d_q       <= '0;
         file_size_q   <= '0;
         data_offset_q <= '0;
         img_width_q   <= '0;
         img_height_q  <= '0;
      end else begin
         ram_valid_q <= accept;
         if (accept) begin
            ram_addr_q <= cnt_q[ADDR_W-1:0];
            ram_d_q    <= in_data;
            cnt_q      <= cnt_q + 32'd1;
            if (cnt_q >= 32'd2 && cnt_q <= 32'd5) begin
               file_size_q[{lane, 3'b000} +: 8] <= in_data[7:0];
            end
            if (cnt_q >= 32'd10 && cnt_q <= 32'd13) begin
               data_offset_q[{lane, 3'b000} +: 8] <= in_data[7:0];
            end
            if (cnt_q >= 32'd18 && cnt_q <= 32'd21) begin
               img_width_q[{lane, 3'b000} +: 8] <= in_data[7:0];
            end
            if (cnt_q >= 32'd22 && cnt_q <= 32'd25) begin
               img_height_q[{lane, 3'b000} +: 8] <= in_data[7:0];
            end
         end

         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state_q    <= S_HEADER;
                  cnt_q      <= '0;
                  done_q     <= 1'b0;
                  error_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  in_ready_q <= 1'b1;
               end
            end
            S_HEADER, S_PIXEL: begin
               if (accept) begin
                  if (hdr_bad) begin
                     state_q    <= S_ERROR;
                     error_q    <= 1'b1;
                     busy_q     <= 1'b0;
                     in_ready_q <= 1'b0;
                  end else if (last_byte) begin
                     state_q    <= S_DONE;
                     done_q     <= 1'b1;
                     busy_q     <= 1'b0;
                     in_ready_q <= 1'b0;
                  end else if (state_q == S_HEADER && cnt_q == HDR_LAST) begin
                     state_q <= S_PIXEL;
                  end
               end
            end
            default: begin
               state_q    <= S_IDLE;
               busy_q     <= 1'b0;
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign RAM_valid   = ram_valid_q;
   assign RAM_addr    = ram_addr_q;
   assign RAM_D       = ram_d_q;
   assign busy        = busy_q;
   assign done        = done_q;
`ifdef BMP_HEADER_CHECK_EN
   assign error       = error_q;
`else
   assign error       = 1'b0;
`endif
   assign file_size   = file_size_q;
   assign data_offset = data_offset_q;
   assign img_width   = img_width_q;
   assign img_height  = img_height_q;

endmodule

// File: tb/tb_bmp_load_ctrl.sv
// tb/tb_bmp_load_ctrl.sv - scoreboard bench for bmp_load_ctrl
module tb_bmp_load_ctrl;
   localparam int ADDR_W   = 12;
   localparam int DATA_W   = 8;
   localparam int MAX_SIZE = 200;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_ready;
   logic              RAM_valid;
   logic [ADDR_W-1:0] RAM_addr;
   logic [DATA_W-1:0] RAM_D;
   logic              busy, done, error;
   logic [31:0]       file_size, data_offset, img_width, img_height;

   bmp_load_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_SIZE(MAX_SIZE)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .RAM_valid(RAM_valid), .RAM_addr(RAM_addr), .RAM_D(RAM_D),
      .busy(busy), .done(done), .error(error), .file_size(file_size),
      .data_offset(data_offset), .img_width(img_width), .img_height(img_height)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   logic [7:0]  file_b [0:511];
   logic [19:0] exp_q [$];

   always @(posedge clk) begin : monitor
      logic acc;
      logic [19:0] e;
      acc = in_valid && in_ready && !rst;
      #1;
      checks++;
      if (RAM_valid !== acc) begin
         errors++;
         $display("FAIL ram_valid_pulse: got %b want %b at %0t", RAM_valid, acc, $time);
      end
      if (RAM_valid === 1'b1) begin
         wr_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr %0d data %0h want none", RAM_addr, RAM_D);
         end else begin
            e = exp_q.pop_front();
            if ({RAM_addr, RAM_D} !== e) begin
               errors++;
               $display("FAIL ram_write: got addr %0d data %0h want addr %0d data %0h",
                        RAM_addr, RAM_D, e[19:8], e[7:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic fill_file(input int fsize, input logic [7:0] b0);
      for (int i = 0; i < 512; i++) file_b[i] = 8'(i * 7 + 3);
      file_b[0] = b0;
      file_b[1] = 8'h4D;
      {file_b[5], file_b[4], file_b[3], file_b[2]} = fsize;
      {file_b[9], file_b[8], file_b[7], file_b[6]} = 32'd0;
      {file_b[13], file_b[12], file_b[11], file_b[10]} = 32'd54;
      {file_b[17], file_b[16], file_b[15], file_b[14]} = 32'd40;
      {file_b[21], file_b[20], file_b[19], file_b[18]} = 32'd2;
      {file_b[25], file_b[24], file_b[23], file_b[22]} = 32'd2;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic load_file(input int from, input int to, input bit toggle, input int budget,
                            output int n_acc);
      int idx;
      int cyc;
      idx = from;
      cyc = 0;
      n_acc = 0;
      while (idx < to && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (toggle && (cyc % 2 == 0)) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_data  = file_b[idx];
            if (in_ready) begin
               exp_q.push_back({12'(idx), file_b[idx]});
               idx++;
               n_acc++;
            end
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, error, in_ready, RAM_valid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_status: got %b want 00000", {busy, done, error, in_ready, RAM_valid});
      end
      checks++;
      if ({file_size, data_offset, img_width, img_height, RAM_addr, RAM_D} !== '0) begin
         errors++;
         $display("FAIL reset_fields: got %0h/%0h/%0h/%0h want 0", file_size, data_offset, img_width, img_height);
      end
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({busy, in_ready} !== 2'b00) begin
         errors++;
         $display("FAIL idle_wait: got busy %b ready %b want 0 0", busy, in_ready);
      end
   endtask

   task automatic test_full_load(input bit toggle);
      int n;
      fill_file(70, 8'h42);
      wr_cnt = 0;
      pulse_start();
      checks++;
      if ({busy, in_ready, done} !== 3'b110) begin
         errors++;
         $display("FAIL load_start: got busy/ready/done %b want 110", {busy, in_ready, done});
      end
      load_file(0, 70, toggle, 400, n);
      checks++;
      if (n !== 70) begin
         errors++;
         $display("FAIL load_accepted: got %0d want 70", n);
      end
      checks++;
      if ({done, busy, in_ready, error} !== 4'b1000) begin
         errors++;
         $display("FAIL load_done: got done/busy/ready/error %b want 1000", {done, busy, in_ready, error});
      end
      checks++;
      if (file_size !== 32'd70 || data_offset !== 32'd54 || img_width !== 32'd2 || img_height !== 32'd2) begin
         errors++;
         $display("FAIL header_fields: got %0d/%0d/%0d/%0d want 70/54/2/2", file_size, data_offset, img_width, img_height);
      end
      checks++;
      if (wr_cnt !== 70 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL load_writes: got %0d writes %0d pending want 70 0", wr_cnt, exp_q.size());
      end
   endtask

   task automatic test_start_ignored();
      int n;
      fill_file(70, 8'h42);
      wr_cnt = 0;
      pulse_start();
      load_file(0, 60, 1'b0, 200, n);
      pulse_start();
      checks++;
      if ({busy, done} !== 2'b10) begin
         errors++;
         $display("FAIL start_in_pixel: got busy/done %b want 10", {busy, done});
      end
      load_file(60, 70, 1'b0, 100, n);
      checks++;
      if (n !== 10 || done !== 1'b1 || wr_cnt !== 70) begin
         errors++;
         $display("FAIL start_ignored_tail: got n %0d done %b writes %0d want 10 1 70", n, done, wr_cnt);
      end
   endtask

   task automatic test_reset_midload();
      int n;
      fill_file(70, 8'h42);
      wr_cnt = 0;
      pulse_start();
      load_file(0, 30, 1'b0, 100, n);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, error, in_ready, RAM_valid} !== 5'b0 ||
          {file_size, data_offset, img_width, img_height, RAM_addr, RAM_D} !== '0) begin
         errors++;
         $display("FAIL midload_reset: got status %b size %0d width %0d addr %0d want all 0",
                  {busy, done, error, in_ready, RAM_valid}, file_size, img_width, RAM_addr);
      end
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b1;
      in_data = 8'hAA;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if ({busy, in_ready} !== 2'b00 || wr_cnt !== 30) begin
         errors++;
         $display("FAIL no_resume: got busy %b ready %b writes %0d want 0 0 30", busy, in_ready, wr_cnt);
      end
      pulse_start();
      load_file(0, 70, 1'b0, 200, n);
      checks++;
      if (n !== 70 || done !== 1'b1 || wr_cnt !== 100 || img_height !== 32'd2) begin
         errors++;
         $display("FAIL reload: got n %0d done %b writes %0d height %0d want 70 1 100 2", n, done, wr_cnt, img_height);
      end
   endtask

   task automatic test_bad_magic();
      int n;
      fill_file(70, 8'h41);
      wr_cnt = 0;
      pulse_start();
      load_file(0, 70, 1'b0, 200, n);
      checks++;
`ifdef BMP_HEADER_CHECK_EN
      if (n !== 1 || error !== 1'b1 || in_ready !== 1'b0 || wr_cnt !== 1) begin
         errors++;
         $display("FAIL bad_magic: got n %0d error %b ready %b writes %0d want 1 1 0 1", n, error, in_ready, wr_cnt);
      end
`else
      if (n !== 70 || done !== 1'b1 || error !== 1'b0 || wr_cnt !== 70) begin
         errors++;
         $display("FAIL bad_magic: got n %0d done %b error %b writes %0d want 70 1 0 70", n, done, error, wr_cnt);
      end
`endif
   endtask

   task automatic test_oversize();
      int n;
      fill_file(MAX_SIZE + 100, 8'h42);
      wr_cnt = 0;
      pulse_start();
      load_file(0, MAX_SIZE + 100, 1'b0, 700, n);
      checks++;
`ifdef BMP_HEADER_CHECK_EN
      if (n !== 6 || error !== 1'b1 || wr_cnt !== 6) begin
         errors++;
         $display("FAIL oversize: got n %0d error %b writes %0d want 6 1 6", n, error, wr_cnt);
      end
`else
      if (n !== MAX_SIZE || done !== 1'b1 || error !== 1'b0 || wr_cnt !== MAX_SIZE) begin
         errors++;
         $display("FAIL oversize: got n %0d done %b error %b writes %0d want %0d 1 0 %0d",
                  n, done, error, wr_cnt, MAX_SIZE, MAX_SIZE);
      end
`endif
      checks++;
      if (img_width !== 32'd2 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL oversize_tail: got width %0d pending %0d want 2 0", img_width, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_full_load(1'b0);
      test_full_load(1'b1);
      test_start_ignored();
      test_reset_midload();
      test_bad_magic();
      test_oversize();
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bmp_load_ctrl.md
BMP_LOAD_CTRL -- requirements
Module: bmp_load_ctrl

Interface
- REQ-001 SHALL have parameter ADDR_W, default `ADDR_WIDTH, RAM address width.
- REQ-002 SHALL have parameter DATA_W, default `BYTE_WIDTH, byte width (8).
- REQ-003 SHALL have parameter MAX_SIZE, default `BMP_TOTAL_SIZE, RAM depth in bytes.
- REQ-004 SHALL have port clk, input, 1, sole clock; all logic on the rising edge.
- REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
- REQ-006 SHALL have port start, input, 1, one-cycle request to begin a load.
- REQ-007 SHALL have port in_valid, input, 1, stream byte valid.
- REQ-008 SHALL have port in_data, input, DATA_W, stream byte in file order.
- REQ-009 SHALL have port in_ready, output, 1, byte accepted when in_valid && in_ready.
- REQ-010 SHALL have ports RAM_valid (output, 1), RAM_addr (output, ADDR_W) and RAM_D (output, DATA_W); together they form the RAM write port.
- REQ-011 SHALL have ports busy, done and error, each output, 1; they report status.
- REQ-012 SHALL have ports file_size, data_offset, img_width and img_height, each output, 32; they hold the parsed header fields.

Function
- REQ-013 SHALL implement the states IDLE, HEADER, PIXEL, DONE and ERROR.
- REQ-014 IDLE: start -> HEADER, byte counter cleared, done/error cleared; in_ready=0.
- REQ-015 start outside IDLE/DONE/ERROR SHALL be ignored; start in DONE or ERROR SHALL begin a new load.
- REQ-016 In HEADER/PIXEL in_ready SHALL be 1; each accepted byte SHALL produce RAM_valid=1, RAM_addr=counter and RAM_D=in_data on the next cycle (registered, latency 1); the counter then increments by 1.
- REQ-017 RAM_valid SHALL be 0 in every cycle with no accepted byte in the previous cycle.
- REQ-018 Header fields SHALL be captured little-endian from bytes 2-5 (file_size), 10-13 (data_offset), 18-21 (img_width) and 22-25 (img_height); each field is updated byte-wise as its bytes are accepted.
- REQ-019 HEADER -> PIXEL after byte 53 is accepted.
- REQ-020 The load limit SHALL be MAX_SIZE until byte 5 is accepted, and min(file_size, MAX_SIZE) thereafter.
- REQ-021 When the accepted byte index equals limit-1 -> DONE; done=1 is held; in_ready=0.
- REQ-022 No RAM write SHALL occur at an address >= MAX_SIZE; the counter SHALL never wrap.
- REQ-023 busy SHALL be 1 in HEADER and PIXEL, else 0.
- REQ-024 in_valid while in_ready=0 SHALL be ignored, with no state change.

Reset
- REQ-025 rst=1 SHALL asynchronously force IDLE, counter=0 and all outputs to 0 (including header fields); this applies mid-load as well.
- REQ-026 After rst deasserts, the block SHALL wait in IDLE for start; a partial image SHALL NOT be resumed.

Configuration
- REQ-027 Macro BMP_HEADER_CHECK_EN SHALL compile in header validation.
- REQ-028 With BMP_HEADER_CHECK_EN defined: byte0 != 0x42 or byte1 != 0x4D -> ERROR; file_size > MAX_SIZE or file_size < 54 (checked on acceptance of byte 5) -> ERROR.
- REQ-029 With BMP_HEADER_CHECK_EN defined, ERROR SHALL assert error=1 (held), in_ready=0 and block further writes; the offending byte itself SHALL still be written.
- REQ-030 Without BMP_HEADER_CHECK_EN: no ERROR state entry, error tied 0, and file_size clamped per REQ-020.

Verification
- REQ-031 Scenario: reset, start, 70-byte valid BMP (file_size=70, offset=54, width 2, height 2), in_valid constant -> 70 writes at addresses 0..69 each one cycle after acceptance; done=1; width=2, height=2.
- REQ-032 Scenario: same file with in_valid toggling 1/0 -> identical RAM contents; RAM_valid pulses only after accepted bytes.
- REQ-033 Scenario: rst asserted after 30 bytes -> all outputs 0 immediately; a new start plus the full file -> correct load from address 0.
- REQ-034 Scenario (macro on): byte0=0x41 -> error=1 after one write to address 0; in_ready=0. Macro off -> load continues.
- REQ-035 Scenario: file_size=MAX_SIZE+100 -> macro on: ERROR after byte 5; macro off: exactly MAX_SIZE writes, then done=1.
- REQ-036 Scenario: start pulsed during PIXEL -> ignored; start in DONE -> new load with done cleared.
